// File: rtl/pet2001ps2_kbd.sv
// PS/2 keyboard front end for the PET core.
// Receives PS/2 scancodes, keeps a 10x8 PET key matrix and drives the active-low
// keyin bus for the row selected on keyrow.
// Optional feature: define PS2_KBD_EXT_EN to map the extended cursor keys
// (E0 72/74/75/6B) onto the PET cursor keys with virtual shift.
module pet2001ps2_kbd #(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [3:0] keyrow,
  output logic [7:0] keyin,
  output logic       ps2_err
);

  localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
  localparam int unsigned ToW   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StBrk, StExt, StExtBrk} state_e;

  logic             clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic             filt_q, filt_prev_q;
  logic [FiltW-1:0] filt_cnt_q;
  logic             fall;

  logic [3:0]       bit_cnt_q;
  logic [7:0]       sr_q;
  logic             parity_q;
  logic [ToW-1:0]   to_cnt_q;
  logic             byte_valid_q;
  logic [7:0]       byte_q;
  logic             err_q;

  state_e           state_q, state_d;
  logic [9:0][7:0]  matrix_q, matrix_d;
  logic             vs_up_q, vs_up_d, vs_left_q, vs_left_d;
  logic [7:0]       map_ent;
  logic [7:0]       vshift_mask;

  // Scancode set 2 -> {valid, row, col}; layout follows the PET graphics keyboard.
  function automatic logic [7:0] map_rom(input logic [6:0] code);
    logic [7:0] m;
    m = 8'h00;
    case (code)
      7'h1C: m = {1'b1, 4'd4, 3'd0};  // A
      7'h23: m = {1'b1, 4'd4, 3'd1};  // D
      7'h34: m = {1'b1, 4'd4, 3'd2};  // G
      7'h3B: m = {1'b1, 4'd4, 3'd3};  // J
      7'h4B: m = {1'b1, 4'd4, 3'd4};  // L
      7'h25: m = {1'b1, 4'd4, 3'd6};  // 4
      7'h36: m = {1'b1, 4'd4, 3'd7};  // 6
      7'h1B: m = {1'b1, 4'd5, 3'd0};  // S
      7'h2B: m = {1'b1, 4'd5, 3'd1};  // F
      7'h33: m = {1'b1, 4'd5, 3'd2};  // H
      7'h42: m = {1'b1, 4'd5, 3'd3};  // K
      7'h2E: m = {1'b1, 4'd5, 3'd6};  // 5
      7'h15: m = {1'b1, 4'd2, 3'd0};  // Q
      7'h24: m = {1'b1, 4'd2, 3'd1};  // E
      7'h2C: m = {1'b1, 4'd2, 3'd2};  // T
      7'h3C: m = {1'b1, 4'd2, 3'd3};  // U
      7'h44: m = {1'b1, 4'd2, 3'd4};  // O
      7'h3D: m = {1'b1, 4'd2, 3'd6};  // 7
      7'h46: m = {1'b1, 4'd2, 3'd7};  // 9
      7'h1D: m = {1'b1, 4'd3, 3'd0};  // W
      7'h2D: m = {1'b1, 4'd3, 3'd1};  // R
      7'h35: m = {1'b1, 4'd3, 3'd2};  // Y
      7'h43: m = {1'b1, 4'd3, 3'd3};  // I
      7'h4D: m = {1'b1, 4'd3, 3'd4};  // P
      7'h3E: m = {1'b1, 4'd3, 3'd6};  // 8
      7'h4A: m = {1'b1, 4'd3, 3'd7};  // /
      7'h1A: m = {1'b1, 4'd6, 3'd0};  // Z
      7'h21: m = {1'b1, 4'd6, 3'd1};  // C
      7'h32: m = {1'b1, 4'd6, 3'd2};  // B
      7'h3A: m = {1'b1, 4'd6, 3'd3};  // M
      7'h4C: m = {1'b1, 4'd6, 3'd4};  // ;
      7'h5A: m = {1'b1, 4'd6, 3'd5};  // enter
      7'h16: m = {1'b1, 4'd6, 3'd6};  // 1
      7'h26: m = {1'b1, 4'd6, 3'd7};  // 3
      7'h22: m = {1'b1, 4'd7, 3'd0};  // X
      7'h2A: m = {1'b1, 4'd7, 3'd1};  // V
      7'h31: m = {1'b1, 4'd7, 3'd2};  // N
      7'h41: m = {1'b1, 4'd7, 3'd3};  // ,
      7'h1E: m = {1'b1, 4'd7, 3'd6};  // 2
      7'h12: m = {1'b1, 4'd8, 3'd0};  // left shift
      7'h5B: m = {1'b1, 4'd8, 3'd2};  // ]
      7'h59: m = {1'b1, 4'd8, 3'd5};  // right shift
      7'h45: m = {1'b1, 4'd8, 3'd6};  // 0
      7'h4E: m = {1'b1, 4'd8, 3'd7};  // -
      7'h0D: m = {1'b1, 4'd9, 3'd0};  // tab -> RVS
      7'h54: m = {1'b1, 4'd9, 3'd1};  // [
      7'h29: m = {1'b1, 4'd9, 3'd2};  // space
      7'h76: m = {1'b1, 4'd9, 3'd4};  // esc -> STOP
      7'h49: m = {1'b1, 4'd9, 3'd6};  // .
      7'h55: m = {1'b1, 4'd9, 3'd7};  // =
      default: m = 8'h00;
    endcase
    return m;
  endfunction

  // Two-flop synchronizers, preset high (idle bus level).
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Glitch filter: the filtered clock follows only after FILTER_LEN differing samples in a row.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      filt_cnt_q  <= '0;
    end else begin
      filt_prev_q <= filt_q;
      if (clk_s2_q == filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FiltW'(FILTER_LEN - 1)) begin
        filt_q     <= clk_s2_q;
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + 1'b1;
      end
    end
  end

  assign fall = filt_prev_q & ~filt_q;

  // Frame receiver with start/parity/stop checking and inter-edge timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_q    <= '0;
      sr_q         <= '0;
      parity_q     <= 1'b0;
      to_cnt_q     <= '0;
      byte_valid_q <= 1'b0;
      byte_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      err_q        <= 1'b0;
      if (fall) begin
        to_cnt_q <= '0;
        if (bit_cnt_q == 4'd0) begin
          if (dat_s2_q) err_q <= 1'b1;
          else          bit_cnt_q <= 4'd1;
        end else if (bit_cnt_q <= 4'd8) begin
          sr_q      <= {dat_s2_q, sr_q[7:1]};
          bit_cnt_q <= bit_cnt_q + 4'd1;
        end else if (bit_cnt_q == 4'd9) begin
          parity_q  <= dat_s2_q;
          bit_cnt_q <= 4'd10;
        end else begin
          bit_cnt_q <= 4'd0;
          if (dat_s2_q && (^{sr_q, parity_q})) begin
            byte_valid_q <= 1'b1;
            byte_q       <= sr_q;
          end else begin
            err_q <= 1'b1;
          end
        end
      end else if (bit_cnt_q != 4'd0) begin
        if (to_cnt_q == ToW'(TIMEOUT - 1)) begin
          bit_cnt_q <= 4'd0;
          to_cnt_q  <= '0;
          err_q     <= 1'b1;
        end else begin
          to_cnt_q <= to_cnt_q + 1'b1;
        end
      end else begin
        to_cnt_q <= '0;
      end
    end
  end

  assign ps2_err = err_q;
  assign map_ent = map_rom(byte_q[6:0]);

  // Decoder next state: prefix tracking plus matrix and virtual-shift updates.
  always_comb begin
    state_d   = state_q;
    matrix_d  = matrix_q;
    vs_up_d   = vs_up_q;
    vs_left_d = vs_left_q;
    if (byte_valid_q) begin
      state_d = StIdle;
      if (byte_q == 8'h00 || byte_q == 8'hFF) begin
        matrix_d  = '0;
        vs_up_d   = 1'b0;
        vs_left_d = 1'b0;
      end else if (byte_q == 8'hE0) begin
        state_d = StExt;
      end else if (byte_q == 8'hF0) begin
        state_d = (state_q == StExt || state_q == StExtBrk) ? StExtBrk : StBrk;
      end else if (!byte_q[7]) begin
        // Remaining codes >= 0x80 (AA, FA, EE, FE, ...) fall through as ignored.
        unique case (state_q)
          StIdle, StBrk: begin
            if (map_ent[7] && map_ent[6:3] < 4'd10) begin
              matrix_d[map_ent[6:3]][map_ent[2:0]] = (state_q == StIdle);
            end
          end
          StExt, StExtBrk: begin
`ifdef PS2_KBD_EXT_EN
            case (byte_q[6:0])
              7'h72: matrix_d[1][7] = (state_q == StExt);
              7'h74: matrix_d[0][7] = (state_q == StExt);
              7'h75: begin
                matrix_d[1][7] = (state_q == StExt);
                vs_up_d        = (state_q == StExt);
              end
              7'h6B: begin
                matrix_d[0][7] = (state_q == StExt);
                vs_left_d      = (state_q == StExt);
              end
              default: ;
            endcase
`else
            // Extended codes are consumed but never touch the matrix.
`endif
          end
          default: ;
        endcase
      end
    end
  end

  // Decoder state, matrix and virtual-shift registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      matrix_q  <= '0;
      vs_up_q   <= 1'b0;
      vs_left_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      matrix_q  <= matrix_d;
      vs_up_q   <= vs_up_d;
      vs_left_q <= vs_left_d;
    end
  end

  assign vshift_mask = {2'b00, (keyrow == 4'd8) && (vs_up_q || vs_left_q), 5'b00000};

  // Row readout: active-low columns, rows 10-15 read as all released.
  always_comb begin
    keyin = 8'hFF;
    for (int r = 0; r < 10; r++) begin
      if (keyrow == 4'(r)) keyin = ~(matrix_q[r] | vshift_mask);
    end
  end

endmodule

// File: tb/tb_pet2001ps2_kbd.sv
// Scoreboard bench for pet2001ps2_kbd: stimulus queues expected row reads and
// error pulses; independent checker/monitor processes consume them.
module tb_pet2001ps2_kbd;

  localparam int unsigned Timeout = 1000;
  localparam int          Half    = 20;

`ifdef PS2_KBD_EXT_EN
  localparam logic [7:0] ExpUpRow1 = 8'h7F;
  localparam logic [7:0] ExpUpRow8 = 8'hDF;
`else
  localparam logic [7:0] ExpUpRow1 = 8'hFF;
  localparam logic [7:0] ExpUpRow8 = 8'hFF;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] keyrow;
  logic [7:0] keyin;
  logic       ps2_err;

  pet2001ps2_kbd #(
    .FILTER_LEN(8),
    .TIMEOUT   (Timeout)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .keyrow  (keyrow),
    .keyin   (keyin),
    .ps2_err (ps2_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] row;
    logic [7:0] exp;
    string      name;
  } chk_t;

  chk_t  chk_q[$];
  string err_exp_q[$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  task automatic expect_key(input logic [3:0] r, input logic [7:0] e, input string n);
    chk_t c;
    c.row  = r;
    c.exp  = e;
    c.name = n;
    chk_q.push_back(c);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (Half) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (Half) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_ok, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par_ok ? ~^d : ^d);
    send_bit(stop);
    ps2_data = 1'b1;
    repeat (Half) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_frame(d, 1'b1, 1'b1);
  endtask

  // Wait (bounded) until the checker has consumed every queued row read.
  task automatic drain();
    int k;
    k = 0;
    while (chk_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (chk_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d row checks still pending, required 0", chk_q.size());
      chk_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Row-read checker: selects the queued row and compares keyin mid-cycle.
  initial begin : keyin_checker
    chk_t c;
    forever begin
      @(negedge clk);
      if (chk_q.size() != 0) begin
        c = chk_q.pop_front();
        keyrow = c.row;
        #1;
        n_cmp++;
        if (keyin !== c.exp) begin
          n_fail++;
          $display("FAIL %s: keyrow=%0d keyin=%h, required %h", c.name, c.row, keyin, c.exp);
        end
      end
    end
  end

  // Error monitor: every ps2_err pulse must match a queued expectation and last one cycle.
  initial begin : err_monitor
    forever begin
      @(negedge clk);
      if (ps2_err === 1'b1) begin
        n_cmp++;
        if (err_exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_err: ps2_err=1 at %0t, required no pulse", $time);
        end else begin
          void'(err_exp_q.pop_front());
        end
        @(negedge clk);
        n_cmp++;
        if (ps2_err !== 1'b0) begin
          n_fail++;
          $display("FAIL err_width: ps2_err=%b one cycle after pulse, required 0", ps2_err);
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    keyrow   = 4'd0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Reset state: every row released, including out-of-range rows.
    for (int r = 0; r < 10; r++) expect_key(4'(r), 8'hFF, "reset_row");
    expect_key(4'd12, 8'hFF, "reset_row12");
    expect_key(4'd15, 8'hFF, "reset_row15");
    drain();

    // Make and break A.
    send_byte(8'h1C);
    expect_key(4'd4, 8'hFE, "make_a");
    expect_key(4'd5, 8'hFF, "make_a_other_row");
    drain();
    send_byte(8'hF0);
    send_byte(8'h1C);
    expect_key(4'd4, 8'hFF, "break_a");
    drain();

    // Parity error on space.
    err_exp_q.push_back("parity");
    send_frame(8'h29, 1'b0, 1'b1);
    expect_key(4'd9, 8'hFF, "parity_err_row9");
    drain();

    // Two shifts, release one.
    send_byte(8'h12);
    send_byte(8'h59);
    expect_key(4'd8, 8'hDE, "two_shifts");
    drain();
    send_byte(8'hF0);
    send_byte(8'h12);
    expect_key(4'd8, 8'hDF, "release_lshift");
    drain();
    send_byte(8'hF0);
    send_byte(8'h59);
    expect_key(4'd8, 8'hFF, "release_rshift");
    drain();

    // Timeout after a partial frame, then a good frame.
    err_exp_q.push_back("timeout");
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    ps2_data = 1'b1;
    repeat (Timeout + 50) @(negedge clk);
    send_byte(8'h5A);
    expect_key(4'd6, 8'hDF, "enter_after_timeout");
    drain();
    send_byte(8'hF0);
    send_byte(8'h5A);
    expect_key(4'd6, 8'hFF, "break_enter");
    drain();

    // Overflow clears all keys.
    send_byte(8'h1C);
    send_byte(8'h29);
    expect_key(4'd4, 8'hFE, "pre_overflow_a");
    expect_key(4'd9, 8'hFB, "pre_overflow_space");
    drain();
    send_byte(8'hFF);
    expect_key(4'd4, 8'hFF, "overflow_row4");
    expect_key(4'd9, 8'hFF, "overflow_row9");
    expect_key(4'd12, 8'hFF, "overflow_row12");
    drain();

    // Start bit of 1: single falling edge with data high.
    err_exp_q.push_back("start");
    send_bit(1'b1);
    repeat (Half) @(negedge clk);

    // Short ps2_clk glitch with data high must not look like an edge.
    @(negedge clk);
    ps2_clk = 1'b0;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (40) @(negedge clk);

    // Bad stop bit.
    err_exp_q.push_back("stop");
    send_frame(8'h1C, 1'b1, 1'b0);
    expect_key(4'd4, 8'hFF, "stop_err_row4");
    drain();

    // Extended up arrow, then its break; a normal key must still work afterwards.
    send_byte(8'hE0);
    send_byte(8'h75);
    expect_key(4'd1, ExpUpRow1, "ext_up_row1");
    expect_key(4'd8, ExpUpRow8, "ext_up_row8");
    drain();
    send_byte(8'h1C);
    expect_key(4'd4, 8'hFE, "make_a_after_ext");
    drain();
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    expect_key(4'd1, 8'hFF, "ext_up_break_row1");
    expect_key(4'd8, 8'hFF, "ext_up_break_row8");
    expect_key(4'd4, 8'hFE, "a_still_held");
    drain();

    // Reset mid-frame: no error, matrix cleared, next frame decodes.
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    ps2_data = 1'b1;
    repeat (Timeout + 50) @(negedge clk);
    expect_key(4'd4, 8'hFF, "reset_clears_a");
    drain();
    send_byte(8'h29);
    expect_key(4'd9, 8'hFB, "space_after_reset");
    drain();

    repeat (20) @(negedge clk);
    n_cmp++;
    if (err_exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_err: %0d expected ps2_err pulses not seen, required 0",
               err_exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pet2001ps2_kbd.md
# pet2001ps2_kbd

PS/2 keyboard front end for the PET core. It receives scancodes from a PS/2 keyboard and maintains a 10×8 PET key matrix. It drives the `keyin` bus of the PET hardware for whichever row that hardware selects on `keyrow`. It sits directly upstream of the PET top level's `keyrow`/`keyin` pins, replacing a physical PET keyboard.

## Interface
- `FILTER_LEN`, default 8: consecutive identical synchronized `ps2_clk` samples required before the filtered clock changes state.
- `TIMEOUT`, default 50000: clk cycles without a falling edge that abort a partially received frame.
- `clk` — input, 1 bit: system clock, same clock as the PET core.
- `reset` — input, 1 bit: synchronous, active-high reset.
- `ps2_clk` — input, 1 bit: PS/2 clock, asynchronous, 2-flop synchronized internally.
- `ps2_data` — input, 1 bit: PS/2 data, asynchronous, 2-flop synchronized internally.
- `keyrow` — input, 4 bits: row select from the PET hardware.
- `keyin` — output, 8 bits: active-low column bits for the selected row.
- `ps2_err` — output, 1 bit: one-cycle pulse on any frame error (start, parity, stop, or timeout).

## Operation
- **Receiver:**
  - Shifts a frame on each filtered `ps2_clk` falling edge: start bit (0), 8 data bits LSB first, odd parity bit, stop bit (1).
  - Start bit = 1 → frame discarded, `ps2_err` pulses, bit counter returns to 0.
  - Parity or stop bit wrong at bit 11 → byte discarded, `ps2_err` pulses.
  - Bit counter ≠ 0 and `TIMEOUT` cycles elapse with no edge → counter cleared, `ps2_err` pulses.
- **Decoder FSM states:** IDLE, BRK, EXT, EXT_BRK.
  - IDLE: 0xF0 → BRK; 0xE0 → EXT; otherwise make-code of a normal key.
  - BRK: next byte is a break-code → IDLE.
  - EXT: 0xF0 → EXT_BRK; otherwise extended make → IDLE.
  - EXT_BRK: next byte is an extended break → IDLE.
- **Special bytes:**
  - 0x00 or 0xFF (keyboard overflow) from any state: clear the whole matrix and both virtual-shift flags, go to IDLE.
  - 0xAA, 0xFA, 0xEE, 0xFE from any state: ignored, go to IDLE.
  - Codes ≥ 0x80 that are not prefixes: ignored, go to IDLE.
- **Map:** 128-entry combinational ROM indexed by code[6:0]; entry is {valid, row[3:0], col[2:0]}. Make sets `matrix[row][col]`, break clears it, invalid entry → no change. Mandatory entries:
  - 0x1C (A) → row 4, col 0
  - 0x29 (space) → row 9, col 2
  - 0x5A (enter) → row 6, col 5
  - 0x12 (left shift) → row 8, col 0
  - 0x59 (right shift) → row 8, col 5
- **Output:**
  - `keyin = ~(matrix[keyrow] | vshift_mask)` for `keyrow` 0–9.
  - `keyin = 8'hFF` for `keyrow` 10–15.
  - `vshift_mask` sets col 5 only when `keyrow` = 8 and either virtual-shift flag is set.
  - `keyin` is combinational from `keyrow` and registered state.
- **Repeats:** typematic repeat makes are idempotent.
- **Simultaneous events:** a make and a break of different keys update independent bits.

## Timing
- **Reset values:**
  - Matrix all 0, so `keyin` = 8'hFF.
  - `ps2_err` = 0, FSM in IDLE, bit counter 0, timeout counter 0.
  - Filtered clock and synchronizers preset to 1.
  - Reset mid-frame drops the partial frame, with no error pulse.
- **Edge detect:** falling edge is detected in the cycle the filtered clock register goes 1→0 (cycle N). The data bit is sampled in cycle N from the synchronized `ps2_data`.
- **Stop-bit edge at cycle N:**
  - Byte-valid or `ps2_err` is registered in N+1.
  - Matrix and FSM update at the N+1 clock edge, visible on `keyin` in N+2.
- **Error pulses:** `ps2_err` is exactly one cycle per error event.
- **Filter:** a `ps2_clk` glitch shorter than `FILTER_LEN` cycles produces no edge.

## Configuration
- `PS2_KBD_EXT_EN` defined — the EXT and EXT_BRK paths map extended codes:
  - E0 72 (down) → row 1, col 7.
  - E0 74 (right) → row 0, col 7.
  - E0 75 (up) → row 1, col 7 plus `vshift_up`.
  - E0 6B (left) → row 0, col 7 plus `vshift_left`.
  - The matching break clears the same bits and flag.
  - All other extended codes are ignored.
- `PS2_KBD_EXT_EN` not defined:
  - The FSM still steps through EXT and EXT_BRK so prefixed bytes are consumed.
  - Extended makes and breaks never change the matrix.
  - Both virtual-shift flags are held at 0.

## Test plan
- **Make A:** frame 0x1C, `keyrow` = 4 → `keyin` = 8'hFE from N+2. Then F0 1C → `keyin` = 8'hFF.
- **Parity error:** frame 0x29 with even parity → `ps2_err` pulses one cycle; `keyrow` = 9 still reads 8'hFF.
- **Two keys, one release:** 12, 59 makes, then F0 12 → `keyrow` = 8 reads 8'hDE, then 8'hDF.
- **Timeout:** 5 bits sent, then idle for `TIMEOUT` + 1 cycles → `ps2_err` pulse. The next full frame 0x5A gives `keyin` = 8'hDF on `keyrow` 6.
- **Overflow and out-of-range row:** makes 1C and 29, then 0xFF → all rows read 8'hFF. `keyrow` = 12 always reads 8'hFF.
- **Extended up:**
  - With `PS2_KBD_EXT_EN`: E0 75 → row 1 reads 8'h7F and row 8 reads 8'hDF; E0 F0 75 → both read 8'hFF.
  - Without the macro: E0 75 → both rows stay 8'hFF.
